fifo: RTL and testbench
=======================

# fifo

Single-clock synchronous first-in/first-out buffer: `width`-bit words, `depth` entries, independent write and read enables, registered read data, full/empty status flags. Used as a general-purpose elastic buffer between a producer and a consumer in the same clock domain. All state updates occur on the rising edge of `clk`. Asynchronous active-low reset clears the buffer.

## Interface
- `width`, default 8: data word width in bits.
- `depth`, default 16: number of storage entries.
  - Must be a power of two, ≥ 2.
  - Address width is AW = log2(`depth`), 4 by default.

- `clk`  in  1: clock; all state changes on the rising edge.
- `resetn`  in  1: reset, asynchronous, active-low.
- `datain`  in  `width`: write data, sampled on a rising edge when a write is accepted.
- `we`  in  1: write enable.
- `re`  in  1: read enable.
- `dataout`  out  `width`: registered read data.
- `empty`  out  1: high when the FIFO holds 0 entries.
- `full`  out  1: high when the FIFO holds `depth` entries.

## Operation
- **Storage:** `depth` × `width` register array, with a write pointer and a read pointer.
  - Each pointer is AW+1 bits. The extra MSB is the wrap bit.
- **Flags:** combinational from the pointers.
  - `empty` = pointers equal, including the wrap bit.
  - `full` = address bits equal and wrap bits differ.
- **Write accepted** when `we`=1 and (`full`=0, or `re`=1 with `empty`=0).
  - `datain` is stored at wptr[AW-1:0], then wptr increments.
- **Read accepted** when `re`=1 and `empty`=0.
  - mem[rptr[AW-1:0]] is loaded into `dataout`, then rptr increments.
- **Write when full without a read:** ignored. No state change, no error flag.
- **Read when empty:** ignored. `dataout` holds its previous value.
- **Simultaneous `we`=`re`=1:**
  - Neither full nor empty: both occur, occupancy unchanged.
  - Full: read and write both occur; `full` stays 1.
  - Empty: only the write occurs. There is no bypass, so `dataout` is unchanged and `empty` deasserts next cycle.
- **Pointer wrap:** pointers increment modulo 2·`depth`. Address bits wrap from `depth`-1 to 0 naturally.
- **Memory contents:** not reset. They are undefined until written, which is harmless because reads from unwritten locations cannot be accepted.
- **Data order:** strictly preserved, no data loss except ignored overflow writes.

## Timing
- **Reset (`resetn`=0, asynchronous, immediate):**
  - wptr = rptr = 0, `dataout` = 0.
  - Therefore `empty`=1, `full`=0.
- **Reset release:** takes effect synchronously at the next rising edge; there is no settling cycle.
- **Reset mid-operation:** all buffered data is discarded and the FIFO reads as empty.
- **Write-to-flag latency:**
  - The first accepted write deasserts `empty` immediately after that edge.
  - The `depth`-th net write asserts `full` immediately after that edge.
- **Read latency:** 1 cycle. Data appears on `dataout` after the rising edge at which `re`=1 is sampled with `empty`=0.
- **Write-to-read latency:** minimum 1 cycle. A word written at edge N can be read at edge N+1, visible on `dataout` after N+1.
- **Flag updates:** `empty` and `full` change only after rising edges, or asynchronously on reset.
- **Inputs:** sampled on rising edges only. Benches drive them on the falling edge.

## Test plan
- **Reset:** assert `resetn`=0 for one cycle, then release.
  - Expect `empty`=1, `full`=0, `dataout`=0.
- **Fill:** write 16 words (e.g. 0x24, 0x81, 0x09, …) with `we`=1, `re`=0.
  - `empty` drops after the 1st edge.
  - `full`=1 after the 16th edge.
- **Overflow:** a 17th write with value 0xAA while full.
  - `full` stays 1.
  - A subsequent drain never returns 0xAA.
- **Drain:** 16 reads with `we`=0, `re`=1.
  - `dataout` returns 0x24, 0x81, 0x09, … in write order, each one cycle after its read edge.
  - `full` drops after the 1st read.
  - `empty`=1 after the 16th read.
- **Underflow:** an extra read while empty.
  - `dataout` holds the last word.
  - Pointers are unchanged, `empty` stays 1.
- **Simultaneous read/write and wrap:**
  - Hold 8 words, then assert `we`=`re`=1 for 20 cycles. Occupancy stays 8, flags are constant, data stays in order across the pointer wrap.
  - Repeat with the FIFO full: `full` stays 1.
  - Repeat with the FIFO empty: only the write occurs, `empty`=0 next cycle.

Source files
------------

// File: rtl/fifo.sv
// Single-clock synchronous FIFO with registered read data.
// Pointers carry one extra wrap bit, so the full and empty flags come
// straight from a pointer comparison with no separate occupancy counter.
module fifo #(
  parameter int width = 8,
  parameter int depth = 16
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic [width-1:0] datain,
  input  logic             we,
  input  logic             re,
  output logic [width-1:0] dataout,
  output logic             empty,
  output logic             full
);

  localparam int AW = $clog2(depth);
  localparam logic [AW:0] ptr_one = (AW+1)'(1);

  logic [width-1:0] mem [depth];
  logic [AW:0]      wptr;
  logic [AW:0]      rptr;
  logic             wr_ok;
  logic             rd_ok;

  // Flags: equal pointers mean empty; equal addresses with opposite wrap bits mean full.
  assign empty = (wptr == rptr);
  assign full  = (wptr[AW-1:0] == rptr[AW-1:0]) && (wptr[AW] != rptr[AW]);

  // Accept logic: a write into a full FIFO is allowed only when a read frees a slot on the same edge.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path can leave it unassigned and infer a latch.
    rd_ok = 1'b0;
    wr_ok = 1'b0;
    if (re && !empty) rd_ok = 1'b1;
    if (we && (!full || rd_ok)) wr_ok = 1'b1;
  end

  // Storage array: written on accepted writes only.
  // NOTE: the array has no reset; reads of unwritten slots cannot be accepted, and omitting reset keeps it mappable to plain flops or RAM.
  always_ff @(posedge clk) begin
    if (wr_ok) mem[wptr[AW-1:0]] <= datain;
  end

  // Pointers and registered read data; reset empties the FIFO and clears dataout.
  always_ff @(posedge clk or negedge resetn) begin
    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    if (!resetn) begin
      wptr    <= '0;
      rptr    <= '0;
      dataout <= '0;
    end else begin
      if (wr_ok) wptr <= wptr + ptr_one;
      if (rd_ok) begin
        dataout <= mem[rptr[AW-1:0]];
        rptr    <= rptr + ptr_one;
      end
    end
  end

endmodule

// File: tb/tb_fifo.sv
// Self-checking bench for fifo: a queue-based reference model checked every
// cycle, plus hand-computed expectations for reset, fill, overflow, drain,
// underflow, simultaneous read/write across the wrap, and mid-run reset.
module tb_fifo;

  localparam int width = 8;
  localparam int depth = 16;

  logic             clk = 1'b0;
  logic             resetn;
  logic [width-1:0] datain;
  logic             we;
  logic             re;
  logic [width-1:0] dataout;
  logic             empty;
  logic             full;

  int checks   = 0;
  int failures = 0;

  fifo #(.width(width), .depth(depth)) dut (
    .clk     (clk),
    .resetn  (resetn),
    .datain  (datain),
    .we      (we),
    .re      (re),
    .dataout (dataout),
    .empty   (empty),
    .full    (full)
  );

  always #5 clk = ~clk;

  // Fill pattern used by the fill/drain tests.
  logic [7:0] fill_words [16] = '{8'h24, 8'h81, 8'h09, 8'h63, 8'h0D, 8'h8D, 8'h65, 8'h12,
                                  8'h01, 8'h0D, 8'h76, 8'h3D, 8'hED, 8'h8C, 8'hF9, 8'hC6};

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: a queue of buffered words and the last word read out.
  logic [7:0] model_q [$];
  logic [7:0] model_dout;

  always @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      model_q.delete();
      model_dout = 8'h00;
    end else begin
      automatic bit do_rd = re && (model_q.size() > 0);
      automatic bit do_wr = we && ((model_q.size() < depth) || do_rd);
      if (do_rd) model_dout = model_q.pop_front();
      if (do_wr) model_q.push_back(datain);
    end
  end

  // Per-cycle comparison against the model, 1 time unit after the active edge.
  always @(posedge clk) begin
    #1;
    check("model_dataout", dataout, model_dout);
    check("model_empty", 8'(empty), 8'(model_q.size() == 0));
    check("model_full", 8'(full), 8'(model_q.size() == depth));
  end

  // Drive one cycle of inputs on the falling edge.
  task automatic drive(input logic w, input logic r, input logic [7:0] d);
    @(negedge clk);
    we     = w;
    re     = r;
    datain = d;
  endtask

  // Wait until just after the next rising edge has taken effect.
  task automatic after_edge();
    @(posedge clk);
    #2;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

  initial begin
    resetn = 1'b0;
    we     = 1'b0;
    re     = 1'b0;
    datain = 8'h00;
    #1;
    check("reset_empty", 8'(empty), 8'h01);
    check("reset_full", 8'(full), 8'h00);
    check("reset_dataout", dataout, 8'h00);
    @(negedge clk);
    resetn = 1'b1;

    // Fill: empty drops after the first edge, full rises after the 16th.
    for (int i = 0; i < 16; i++) begin
      drive(1'b1, 1'b0, fill_words[i]);
      after_edge();
      check("fill_empty", 8'(empty), 8'h00);
      check("fill_full", 8'(full), 8'(i == 15));
    end

    // Overflow write of 0xAA is ignored.
    drive(1'b1, 1'b0, 8'hAA);
    after_edge();
    check("overflow_full", 8'(full), 8'h01);

    // Drain in write order; 0xAA never appears.
    for (int i = 0; i < 16; i++) begin
      drive(1'b0, 1'b1, 8'h00);
      after_edge();
      check("drain_data", dataout, fill_words[i]);
      check("drain_full", 8'(full), 8'h00);
      check("drain_empty", 8'(empty), 8'(i == 15));
    end

    // Underflow read: dataout holds the last word.
    drive(1'b0, 1'b1, 8'h00);
    after_edge();
    check("underflow_data", dataout, 8'hC6);
    check("underflow_empty", 8'(empty), 8'h01);

    // Hold 8 words, then 20 cycles of simultaneous read/write across the wrap.
    for (int i = 0; i < 8; i++) drive(1'b1, 1'b0, 8'(8'h30 + i));
    for (int i = 0; i < 20; i++) begin
      drive(1'b1, 1'b1, 8'(8'h50 + i));
      after_edge();
      check("rw8_empty", 8'(empty), 8'h00);
      check("rw8_full", 8'(full), 8'h00);
    end
    // Words 0x30..0x37 then 0x50..0x5B have been read; the 20th read returned 0x5B.
    check("rw8_last_data", dataout, 8'h5B);

    // Top up to full, then 20 simultaneous cycles while full.
    for (int i = 0; i < 8; i++) drive(1'b1, 1'b0, 8'(8'h70 + i));
    for (int i = 0; i < 20; i++) begin
      drive(1'b1, 1'b1, 8'(8'h90 + i));
      after_edge();
      check("rwfull_full", 8'(full), 8'h01);
    end

    // Drain everything; the model checks the order every cycle.
    for (int i = 0; i < 16; i++) drive(1'b0, 1'b1, 8'h00);
    after_edge();
    check("rwfull_drained_empty", 8'(empty), 8'h01);
    // Last word of the full-run stream is 0x90+19 = 0xA3.
    check("rwfull_last_data", dataout, 8'hA3);

    // Simultaneous read/write while empty: write only, no bypass.
    drive(1'b1, 1'b1, 8'h5A);
    after_edge();
    check("rwempty_empty", 8'(empty), 8'h00);
    check("rwempty_data_held", dataout, 8'hA3);
    drive(1'b0, 1'b1, 8'h00);
    after_edge();
    check("rwempty_read", dataout, 8'h5A);
    check("rwempty_then_empty", 8'(empty), 8'h01);

    // Reset mid-operation discards buffered data.
    for (int i = 0; i < 3; i++) drive(1'b1, 1'b0, 8'(8'hC0 + i));
    @(negedge clk);
    we = 1'b0;
    re = 1'b0;
    #1;
    check("pre_reset_empty", 8'(empty), 8'h00);
    #2;
    resetn = 1'b0;
    #1;
    check("midreset_empty", 8'(empty), 8'h01);
    check("midreset_full", 8'(full), 8'h00);
    check("midreset_dataout", dataout, 8'h00);
    @(negedge clk);
    resetn = 1'b1;
    drive(1'b0, 1'b1, 8'h00);
    after_edge();
    check("post_reset_read_ignored", dataout, 8'h00);

    drive(1'b0, 1'b0, 8'h00);
    repeat (3) @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
